// File: rtl/carrier_counter.sv
// carrier_counter
// ---------------
// Programmable carrier counter for PWM-style timing. Counts in one of four
// shapes selected by a shadowed mode: up-sawtooth, down-sawtooth, triangle
// or hold. Period and mode requests are only adopted at the carrier boundary
// (the "update event"), so a waveform in progress is never torn.
//
// Parameters
//   WIDTH          counter width in bits
//   DEFAULT_PERIOD active period after asynchronous reset (<= 2^WIDTH-1)
//   RESET_VALUE    count after reset (<= DEFAULT_PERIOD)
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous reset, active low
//   rst_syn    synchronous reset, active high (adopts period/mode at once)
//   e          count enable (tick)
//   mode       requested mode: 00 up, 01 down, 10 triangle, 11 hold
//   period     requested period P, count range 0..P
//   load       synchronous preload strobe
//   load_val   preload value, clamped to the active period
//   load_dir   preload direction for triangle mode (1 up, 0 down)
//   cnt        current count (registered)
//   dir        current direction (1 up, 0 down)
//   at_top     top event (combinational)
//   at_bottom  bottom event (combinational)

module carrier_counter #(
  parameter int WIDTH          = 6,
  parameter int DEFAULT_PERIOD = 41,
  parameter int RESET_VALUE    = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rst_syn,
  input  logic             e,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] period,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             load_dir,
  output logic [WIDTH-1:0] cnt,
  output logic             dir,
  output logic             at_top,
  output logic             at_bottom
);

  typedef enum logic [1:0] {
    MODE_UP   = 2'b00,
    MODE_DOWN = 2'b01,
    MODE_TRI  = 2'b10,
    MODE_HOLD = 2'b11
  } mode_e;

  localparam logic [WIDTH-1:0] ZERO    = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] RST_CNT = WIDTH'(RESET_VALUE);
  localparam logic [WIDTH-1:0] DEF_P   = WIDTH'(DEFAULT_PERIOD);

  // Smaller of two counts; used for every clamp against a period.
  function automatic logic [WIDTH-1:0] f_min(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
    f_min = (a < b) ? a : b;
  endfunction

  logic [WIDTH-1:0] r_cnt;
  logic             r_dir;
  logic [WIDTH-1:0] r_p_act;
  mode_e            r_m_act;

  logic [WIDTH-1:0] w_cnt_nxt;
  logic             w_dir_nxt;
  logic [WIDTH-1:0] w_p_nxt;
  mode_e            w_m_nxt;

  mode_e            w_m_req;
  logic             w_at_max;
  logic             w_at_zero;
  logic             w_p_zero;
  logic             w_dir;
  logic             w_upd_cond;
  logic             w_top_cond;
  logic             w_bot_cond;
  logic             w_ev_ok;
  logic [WIDTH-1:0] w_start_cnt;
  logic             w_start_dir;

  assign w_m_req   = mode_e'(mode);
  assign w_at_max  = (r_cnt == r_p_act);
  assign w_at_zero = (r_cnt == ZERO);
  assign w_p_zero  = (r_p_act == ZERO);
  // Neither reset may produce an event on its own.
  assign w_ev_ok   = e & rst & ~rst_syn;

  // Visible direction: fixed in the sawtooth modes, register otherwise.
  always_comb begin
    w_dir = r_dir;
    case (r_m_act)
      MODE_UP:   w_dir = 1'b1;
      MODE_DOWN: w_dir = 1'b0;
      default:   w_dir = r_dir;
    endcase
  end

  // Boundary conditions (before gating by enable) for update and events.
  always_comb begin
    w_upd_cond = 1'b0;
    w_top_cond = 1'b0;
    w_bot_cond = 1'b0;
    case (r_m_act)
      MODE_UP: begin
        w_upd_cond = w_at_max;
        w_top_cond = w_at_max;
      end
      MODE_DOWN: begin
        w_upd_cond = w_at_zero;
        w_bot_cond = w_at_zero;
      end
      MODE_TRI: begin
        // A zero period degenerates to a point: both events every tick.
        w_upd_cond = (w_at_zero & ~r_dir) | w_p_zero;
        w_top_cond = (w_at_max & r_dir) | w_p_zero;
        w_bot_cond = (w_at_zero & ~r_dir) | w_p_zero;
      end
      MODE_HOLD: begin
        w_upd_cond = 1'b1;
      end
      default: begin
        w_upd_cond = 1'b0;
      end
    endcase
  end

  // Start value of the newly adopted mode at an update event.
  always_comb begin
    w_start_cnt = ZERO;
    w_start_dir = 1'b1;
    case (w_m_req)
      MODE_UP: begin
        w_start_cnt = ZERO;
        w_start_dir = 1'b1;
      end
      MODE_DOWN: begin
        w_start_cnt = period;
        w_start_dir = 1'b0;
      end
      MODE_TRI: begin
        // Triangle-to-triangle skips the repeated zero so the wave stays
        // symmetric (2P ticks per carrier period).
        if (r_m_act == MODE_TRI) begin
          w_start_cnt = (period == ZERO) ? ZERO : ONE;
        end else begin
          w_start_cnt = ZERO;
        end
        w_start_dir = 1'b1;
      end
      MODE_HOLD: begin
        // Frozen count, clamped so it never exceeds the new period.
        w_start_cnt = f_min(r_cnt, period);
        w_start_dir = w_dir;
      end
      default: begin
        w_start_cnt = ZERO;
        w_start_dir = 1'b1;
      end
    endcase
  end

  // Next-state: rst_syn, then load, then enable; otherwise hold.
  always_comb begin
    w_cnt_nxt = r_cnt;
    w_dir_nxt = r_dir;
    w_p_nxt   = r_p_act;
    w_m_nxt   = r_m_act;
    if (rst_syn) begin
      w_p_nxt   = period;
      w_m_nxt   = w_m_req;
      w_cnt_nxt = f_min(RST_CNT, period);
      w_dir_nxt = (w_m_req == MODE_DOWN) ? 1'b0 : 1'b1;
    end else if (load) begin
      w_cnt_nxt = f_min(load_val, r_p_act);
      if (r_m_act == MODE_TRI) begin
        w_dir_nxt = load_dir;
      end else begin
        w_dir_nxt = r_dir;
      end
    end else if (e) begin
      if (w_upd_cond) begin
        w_p_nxt   = period;
        w_m_nxt   = w_m_req;
        w_cnt_nxt = w_start_cnt;
        w_dir_nxt = w_start_dir;
      end else begin
        case (r_m_act)
          MODE_UP:   w_cnt_nxt = r_cnt + ONE;
          MODE_DOWN: w_cnt_nxt = r_cnt - ONE;
          MODE_TRI: begin
            if (r_dir) begin
              if (w_at_max) begin
                w_cnt_nxt = r_p_act - ONE;
                w_dir_nxt = 1'b0;
              end else begin
                w_cnt_nxt = r_cnt + ONE;
              end
            end else begin
              w_cnt_nxt = r_cnt - ONE;
            end
          end
          default: w_cnt_nxt = r_cnt;
        endcase
      end
    end else begin
      w_cnt_nxt = r_cnt;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt   <= RST_CNT;
      r_dir   <= 1'b1;
      r_p_act <= DEF_P;
      r_m_act <= MODE_UP;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_dir   <= w_dir_nxt;
      r_p_act <= w_p_nxt;
      r_m_act <= w_m_nxt;
    end
  end

  assign cnt       = r_cnt;
  assign dir       = w_dir;
  assign at_top    = w_ev_ok & w_top_cond;
  assign at_bottom = w_ev_ok & w_bot_cond;

endmodule

// File: doc/carrier_counter.md
CARRIER_COUNTER -- requirements
Module: carrier_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 6, the counter width in bits.
REQ-002 The block SHALL have parameter DEFAULT_PERIOD, default 41, the active period after asynchronous reset; it SHALL be at most 2^WIDTH-1.
REQ-003 The block SHALL have parameter RESET_VALUE, default 0, the count after reset; it SHALL be at most DEFAULT_PERIOD.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, with all state updated on the rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous active-low reset.
REQ-006 The block SHALL have port rst_syn, input, 1 bit: synchronous reset, active high.
REQ-007 The block SHALL have port e, input, 1 bit: count enable (tick).
REQ-008 The block SHALL have port mode, input, 2 bits: 00 up-sawtooth, 01 down-sawtooth, 10 triangle, 11 hold.
REQ-009 The block SHALL have port period, input, WIDTH bits: requested period P; the count range is 0..P.
REQ-010 The block SHALL have port load, input, 1 bit: synchronous preload strobe.
REQ-011 The block SHALL have port load_val, input, WIDTH bits: preload count.
REQ-012 The block SHALL have port load_dir, input, 1 bit: preload direction (1 up, 0 down); it is used in triangle mode only.
REQ-013 The block SHALL have port cnt, output, WIDTH bits: current count, registered.
REQ-014 The block SHALL have port dir, output, 1 bit: current direction (1 up, 0 down).
REQ-015 The block SHALL have port at_top, output, 1 bit: top event, combinational.
REQ-016 The block SHALL have port at_bottom, output, 1 bit: bottom event, combinational.

Function
REQ-017 The block SHALL hold shadow registers P_act and M_act; counting SHALL use only the shadows, never period or mode directly.
REQ-018 Update precedence SHALL be: rst, then rst_syn, then load, then e; with none of these active, all state SHALL hold.
REQ-019 An update event SHALL occur when e=1 and any of the following holds:
- M_act=00 and cnt==P_act.
- M_act=01 and cnt==0.
- M_act=10, cnt==0 and dir==0.
- M_act=10 and P_act==0.
- M_act=11.
REQ-020 On an update event, P_act SHALL be loaded from period and M_act SHALL be loaded from mode.
REQ-021 Up mode (00), e=1: cnt SHALL increment, except that cnt==P_act SHALL be followed by the new-mode start value.
REQ-022 Down mode (01), e=1: cnt SHALL decrement, except that cnt==0 SHALL be followed by the new-mode start value.
REQ-023 Triangle mode (10), e=1, dir=1: cnt SHALL increment, except at cnt==P_act, where the next cnt SHALL be P_act-1 and dir SHALL become 0.
REQ-024 Triangle mode (10), e=1, dir=0: cnt SHALL decrement, except at cnt==0 (the update event), where the next value SHALL be the new-mode start value.
REQ-025 New-mode start values after an update event SHALL be:
- New up: 0.
- New down: the new P.
- New triangle coming from triangle: cnt=1 with dir=1 (0 if the new P is 0).
- New triangle coming from another mode: cnt=0 with dir=1.
- New hold: cnt unchanged.
REQ-026 Hold mode (11) SHALL freeze cnt and dir and keep both events low.
REQ-027 dir SHALL read 1 in up mode, 0 in down mode, the register value in triangle mode, and the frozen value in hold mode.
REQ-028 at_top SHALL be 1 exactly when e=1 and one of the following holds:
- Up mode and cnt==P_act.
- Triangle mode, cnt==P_act and dir==1.
REQ-029 at_bottom SHALL be 1 exactly when e=1 and one of the following holds:
- Down mode and cnt==0.
- Triangle mode, cnt==0 and dir==0.
REQ-030 When P_act==0, cnt SHALL stay at 0 and, in triangle mode, both at_top and at_bottom SHALL assert on every e.
REQ-031 On load, cnt SHALL become min(load_val, P_act) and, in triangle mode, dir SHALL become load_dir.
REQ-032 In triangle mode, load with load_dir=1 and a clamped value equal to P_act SHALL turn at the next tick.
REQ-033 load SHALL NOT update the shadows and SHALL NOT assert events in its own cycle unless the boundary conditions hold on the current cnt.
REQ-034 Invariant: cnt SHALL never exceed P_act.
REQ-035 Arithmetic SHALL be modulo 2^WIDTH, and no wrap other than the defined boundaries SHALL be reachable.
REQ-036 With e=0, cnt, dir and the shadows SHALL hold and both events SHALL be low.

Reset
REQ-037 When rst=0, the following SHALL apply immediately, regardless of clk:
- cnt=RESET_VALUE.
- dir=1.
- P_act=DEFAULT_PERIOD.
- M_act=00.
REQ-038 When rst_syn=1 at a clock edge, the following SHALL apply:
- P_act=period.
- M_act=mode.
- cnt=min(RESET_VALUE, period).
- dir=1 (0 if the new mode is down).
REQ-039 A reset asserted mid-period SHALL discard any pending period/mode request, and no event SHALL be generated by the reset itself.

Verification
REQ-040 Up sawtooth: mode=00, period=5, e=1 continuously -> cnt 0,1,2,3,4,5,0,1; at_top high only in the cnt=5 cycles.
REQ-041 Triangle: mode=10, period=3, after rst_syn -> cnt 0,1,2,3,2,1,0,1,2,3; at_top at cnt=3 (dir=1); at_bottom at the second and later cnt=0; triangle period is 6 ticks.
REQ-042 Shadowed period change: up mode with P_act=5, period set to 2 at cnt=2 -> 3,4,5,0,1,2,0.
REQ-043 Mode change: down to up at the boundary -> the change takes effect after cnt=0, then 0,1,2...
REQ-044 Load clamp: P_act=5, load_val=9 -> cnt=5.
REQ-045 Triangle load: load_val=3, load_dir=0 -> 3,2,1,0,1; at_bottom at 0.
REQ-046 Enable gating: e=0 held at cnt=P_act in up mode -> cnt frozen, at_top low; raising e -> at_top high that cycle, then wrap.
REQ-047 Async reset: rst pulsed low at cnt=4, period=7 -> cnt=0 immediately, P_act=41; after release, counting resumes 0,1,... until cnt=41, then the pending period 7 is adopted.
